// File: rtl/fifo8_reg_ctrl.sv
// Pointer/count sequencer for an 8-entry register-bank FIFO: drives per-entry write enables and the read-mux select.
// Optional almost_full/almost_empty outputs are built when FIFO8_ALMOST_FLAGS_EN is defined.
module fifo8_reg_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [DEPTH-1:0] wr_sel,
  output logic [AW-1:0]    rd_sel,
  output logic [AW:0]      cnt,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err,
  output logic [2:0]       state
`ifdef FIFO8_ALMOST_FLAGS_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_NO_OP    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_WR_ERROR = 3'd3,
    ST_READ     = 3'd4,
    ST_RD_ERROR = 3'd5,
    ST_RW       = 3'd6
  } state_t;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;
  logic          wr_rej, rd_rej;

  // Flags come from the registered count only, so they lag an update by one cycle.
  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign cnt   = cnt_q;
  assign state = state_q;

`ifdef FIFO8_ALMOST_FLAGS_EN
  assign almost_full  = (cnt_q >= (CNT_FULL - CNT_ONE));
  assign almost_empty = (cnt_q <= CNT_ONE);
`endif

  // Reset gating keeps every bank enable quiet in a reset cycle.
  assign push_ok = reset_n & wr_en & ~full;
  assign pop_ok  = reset_n & rd_en & ~empty;
  assign wr_rej  = wr_en & full;
  assign rd_rej  = rd_en & empty;

  assign rd_sel = rd_ptr_q;

  always_comb begin
    wr_sel = '0;
    if (push_ok) begin
      wr_sel[wr_ptr_q] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = ST_NO_OP;
    if (push_ok && pop_ok) begin
      state_d = ST_RW;
    end else if (push_ok) begin
      state_d = ST_WRITE;
    end else if (pop_ok) begin
      state_d = ST_READ;
    end else if (wr_rej) begin
      state_d = ST_WR_ERROR;
    end else if (rd_rej) begin
      state_d = ST_RD_ERROR;
    end else begin
      state_d = ST_NO_OP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wr_ack   <= 1'b0;
      wr_err   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      wr_ack <= push_ok;
      wr_err <= wr_rej;
      rd_ack <= pop_ok;
      rd_err <= rd_rej;
    end
  end

endmodule

// File: tb/tb_fifo8_reg_ctrl.sv
// Bench for fifo8_reg_ctrl: a queue-based FIFO model feeds expected records to a scoreboard monitor.
module tb_fifo8_reg_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wr_sel;
  logic [2:0] rd_sel;
  logic [3:0] cnt;
  logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [2:0] state;
`ifdef FIFO8_ALMOST_FLAGS_EN
  logic       almost_full, almost_empty;
`endif

  fifo8_reg_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wr_sel  (wr_sel),
    .rd_sel  (rd_sel),
    .cnt     (cnt),
    .full    (full),
    .empty   (empty),
    .wr_ack  (wr_ack),
    .wr_err  (wr_err),
    .rd_ack  (rd_ack),
    .rd_err  (rd_err),
    .state   (state)
`ifdef FIFO8_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in register bank, enabled by the DUT's wr_sel.
  logic [7:0] data_in;
  logic [7:0] bank [8];
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_sel[i]) bank[i] <= data_in;
    end
  end

  // ---------------- scoreboard record ----------------
  typedef struct packed {
    logic       chk_rd;
    logic [2:0] rd_sel;
    logic [7:0] wr_sel;
    logic       chk_data;
    logic [7:0] data;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       wr_ack;
    logic       wr_err;
    logic       rd_ack;
    logic       rd_err;
    logic [2:0] state;
    logic       afull;
    logic       aempty;
  } exp_t;
  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a byte queue plus running push/pop positions.
  logic [7:0] model_q[$];
  int         wr_pos = 0;
  int         rd_pos = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rn, input logic w, input logic r);
    exp_t e;
    logic push, pop;
    @(negedge clk);
    reset_n = rn;
    wr_en   = w;
    rd_en   = r;
    data_in = 8'($urandom_range(0, 255));
    e = '0;
    e.chk_rd = rn;
    e.rd_sel = 3'(rd_pos);
    if (!rn) begin
      model_q.delete();
      wr_pos   = 0;
      rd_pos   = 0;
      e.wr_sel = 8'h00;
      e.state  = 3'd0;
    end else begin
      push = w && (model_q.size() < 8);
      pop  = r && (model_q.size() > 0);
      e.wr_sel   = push ? 8'(1 << wr_pos) : 8'h00;
      e.chk_data = pop;
      e.data     = pop ? model_q[0] : 8'h00;
      if (pop) begin
        void'(model_q.pop_front());
        rd_pos = (rd_pos + 1) % 8;
      end
      if (push) begin
        model_q.push_back(data_in);
        wr_pos = (wr_pos + 1) % 8;
      end
      e.wr_ack = push;
      e.wr_err = w && !push;
      e.rd_ack = pop;
      e.rd_err = r && !pop;
      if (push && pop)  e.state = 3'd6;
      else if (push)    e.state = 3'd2;
      else if (pop)     e.state = 3'd4;
      else if (w)       e.state = 3'd3;
      else if (r)       e.state = 3'd5;
      else              e.state = 3'd1;
    end
    e.cnt    = 4'(model_q.size());
    e.full   = (model_q.size() == 8);
    e.empty  = (model_q.size() == 0);
    e.afull  = (model_q.size() >= 7);
    e.aempty = (model_q.size() <= 1);
    exp_q.push_back(EW'(e));
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_t'(exp_q.pop_front());
        chk("wr_sel", int'(wr_sel), int'(e.wr_sel));
        if (e.chk_rd)   chk("rd_sel", int'(rd_sel), int'(e.rd_sel));
        if (e.chk_data) chk("rd_data", int'(bank[rd_sel]), int'(e.data));
        @(posedge clk);
        #1;
        chk("cnt",    int'(cnt),    int'(e.cnt));
        chk("full",   int'(full),   int'(e.full));
        chk("empty",  int'(empty),  int'(e.empty));
        chk("wr_ack", int'(wr_ack), int'(e.wr_ack));
        chk("wr_err", int'(wr_err), int'(e.wr_err));
        chk("rd_ack", int'(rd_ack), int'(e.rd_ack));
        chk("rd_err", int'(rd_err), int'(e.rd_err));
        chk("state",  int'(state),  int'(e.state));
`ifdef FIFO8_ALMOST_FLAGS_EN
        chk("almost_full",  int'(almost_full),  int'(e.afull));
        chk("almost_empty", int'(almost_empty), int'(e.aempty));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wr_prob;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;

    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // fill, overflow, drain, underflow
    push_n(9);
    pop_n(9);

    // pointer wrap
    drive(1'b0, 1'b0, 1'b0);
    push_n(5);
    pop_n(5);
    push_n(6);

    // simultaneous requests at cnt 3, empty and full
    pop_n(3);
    drive(1'b1, 1'b1, 1'b1);
    pop_n(3);
    drive(1'b1, 1'b1, 1'b1);
    push_n(7);
    drive(1'b1, 1'b1, 1'b1);

    // reset mid-burst at cnt 4 with a push pending
    pop_n(3);
    drive(1'b0, 1'b1, 1'b0);
    push_n(2);
    pop_n(2);

    // randomized traffic with phases of fill- and drain-bias
    for (int k = 0; k < 800; k++) begin
      wr_prob = ((k / 100) % 2 == 0) ? 70 : 30;
      drive($urandom_range(0, 99) != 0,
            $urandom_range(0, 99) < wr_prob,
            $urandom_range(0, 99) < (100 - wr_prob));
    end
    drive(1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
